// File: rtl/mer_power_accumulator_if.sv
// Symbol-rate sample stream into the MER power accumulator and its window results.
interface mer_power_accumulator_if #(
    parameter int unsigned DATA_WIDTH = 18
);
    logic                           clk_en;
    logic                           start;
    logic signed [DATA_WIDTH-1:0]   errorless_decision_variable;
    logic signed [DATA_WIDTH-1:0]   error;
    logic                           busy;
    logic                           result_valid;
    logic [2*DATA_WIDTH-1:0]        signal_power;
    logic [2*DATA_WIDTH-1:0]        error_power;
    logic [DATA_WIDTH-1:0]          peak_error;

    modport master (
        output clk_en,
        output start,
        output errorless_decision_variable,
        output error,
        input  busy,
        input  result_valid,
        input  signal_power,
        input  error_power,
        input  peak_error
    );

    modport slave (
        input  clk_en,
        input  start,
        input  errorless_decision_variable,
        input  error,
        output busy,
        output result_valid,
        output signal_power,
        output error_power,
        output peak_error
    );
endinterface

// File: rtl/mer_power_accumulator.sv
// Accumulates reference and error power over 2^LOG2_SYMBOLS symbols and reports the
// window means plus the peak |error| with a one-clock result_valid pulse.
module mer_power_accumulator #(
    parameter int unsigned DATA_WIDTH   = 18,
    parameter int unsigned LOG2_SYMBOLS = 10
) (
    input logic                    clk,
    input logic                    reset,
    mer_power_accumulator_if.slave bus
);
    localparam int unsigned SqW  = 2 * DATA_WIDTH;
    localparam int unsigned AccW = SqW + LOG2_SYMBOLS;
    localparam int unsigned CntW = LOG2_SYMBOLS + 1;
    localparam logic [CntW-1:0] LastSym = CntW'((1 << LOG2_SYMBOLS) - 1);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e state_q, state_d;

    logic signed [SqW-1:0]   ref_ext, err_ext;
    logic [SqW-1:0]          sig_sq_d, err_sq_d, sig_sq_q, err_sq_q;
    logic [DATA_WIDTH-1:0]   abs_err_d, abs_err_q;
    logic [AccW-1:0]         sig_acc_d, sig_acc_q, err_acc_d, err_acc_q;
    logic [DATA_WIDTH-1:0]   peak_d, peak_q;
    logic [CntW-1:0]         sym_cnt_d, sym_cnt_q;
    logic [SqW-1:0]          signal_power_d, signal_power_q;
    logic [SqW-1:0]          error_power_d, error_power_q;
    logic [DATA_WIDTH-1:0]   peak_error_d, peak_error_q;
    logic                    result_valid_d, result_valid_q;

    // Squares are formed at full 2*DATA_WIDTH so the most negative input squares exactly.
    always_comb begin
        ref_ext   = SqW'(bus.errorless_decision_variable);
        err_ext   = SqW'(bus.error);
        sig_sq_d  = ref_ext * ref_ext;
        err_sq_d  = err_ext * err_ext;
        abs_err_d = bus.error[DATA_WIDTH-1] ? unsigned'(-bus.error) : unsigned'(bus.error);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_sq_q  <= '0;
            err_sq_q  <= '0;
            abs_err_q <= '0;
        end else if (bus.clk_en) begin
            sig_sq_q  <= sig_sq_d;
            err_sq_q  <= err_sq_d;
            abs_err_q <= abs_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sig_acc_d      = sig_acc_q;
        err_acc_d      = err_acc_q;
        peak_d         = peak_q;
        sym_cnt_d      = sym_cnt_q;
        signal_power_d = signal_power_q;
        error_power_d  = error_power_q;
        peak_error_d   = peak_error_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StAccum;
                    sig_acc_d = '0;
                    err_acc_d = '0;
                    peak_d    = '0;
                    sym_cnt_d = '0;
                end
            end
            StAccum: begin
                if (bus.clk_en) begin
                    sig_acc_d = sig_acc_q + AccW'(sig_sq_q);
                    err_acc_d = err_acc_q + AccW'(err_sq_q);
                    if (abs_err_q > peak_q) begin
                        peak_d = abs_err_q;
                    end
                    sym_cnt_d = sym_cnt_q + CntW'(1);
                    if (sym_cnt_q == LastSym) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                signal_power_d = SqW'(sig_acc_q >> LOG2_SYMBOLS);
                error_power_d  = SqW'(err_acc_q >> LOG2_SYMBOLS);
                peak_error_d   = peak_q;
                result_valid_d = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            sig_acc_q      <= '0;
            err_acc_q      <= '0;
            peak_q         <= '0;
            sym_cnt_q      <= '0;
            signal_power_q <= '0;
            error_power_q  <= '0;
            peak_error_q   <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sig_acc_q      <= sig_acc_d;
            err_acc_q      <= err_acc_d;
            peak_q         <= peak_d;
            sym_cnt_q      <= sym_cnt_d;
            signal_power_q <= signal_power_d;
            error_power_q  <= error_power_d;
            peak_error_q   <= peak_error_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.result_valid = result_valid_q;
    assign bus.signal_power = signal_power_q;
    assign bus.error_power  = error_power_q;
    assign bus.peak_error   = peak_error_q;
endmodule

// File: tb/tb_mer_power_accumulator.sv
// Directed windows for the MER power accumulator, checked every cycle against a
// behavioural window model plus literal expectations at each result.
module tb_mer_power_accumulator;
    localparam int unsigned DW = 18;
    localparam int unsigned L2 = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mer_power_accumulator_if #(.DATA_WIDTH(DW)) bus ();

    mer_power_accumulator #(
        .DATA_WIDTH   (DW),
        .LOG2_SYMBOLS (L2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Symbol-rate enable: one clock high every 16 clocks.
    int div = 0;
    initial begin
        bus.clk_en = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 16;
            bus.clk_en = (div == 0);
        end
    end

    // Behavioural model: a window opens on an accepted start, sums the squares of the
    // samples captured at the enable preceding each of the next 16 enables, and
    // publishes the means one clock after the last of them.
    longint m_last_ref, m_last_err, m_sum_s, m_sum_e, m_max;
    longint m_sig, m_errp, m_peak, m_abs;
    int     m_n;
    bit     m_busy, m_rv, m_done;
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_last_ref = 0; m_last_err = 0; m_sum_s = 0; m_sum_e = 0; m_max = 0;
                m_sig = 0; m_errp = 0; m_peak = 0; m_n = 0;
                m_busy = 0; m_rv = 0; m_done = 0;
            end else begin
                m_rv = 0;
                if (m_done) begin
                    m_sig  = m_sum_s / 16;
                    m_errp = m_sum_e / 16;
                    m_peak = m_max;
                    m_rv   = 1;
                    m_done = 0;
                    m_busy = 0;
                end else if (!m_busy) begin
                    if (bus.start) begin
                        m_busy = 1; m_n = 0; m_sum_s = 0; m_sum_e = 0; m_max = 0;
                    end
                end else if (bus.clk_en) begin
                    m_sum_s += m_last_ref * m_last_ref;
                    m_sum_e += m_last_err * m_last_err;
                    m_abs = (m_last_err < 0) ? -m_last_err : m_last_err;
                    if (m_abs > m_max) m_max = m_abs;
                    m_n++;
                    if (m_n == 16) m_done = 1;
                end
                if (bus.clk_en) begin
                    m_last_ref = longint'(bus.errorless_decision_variable);
                    m_last_err = longint'(bus.error);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy",         longint'(bus.busy),         longint'(m_busy));
            chk("result_valid", longint'(bus.result_valid), longint'(m_rv));
            chk("signal_power", longint'(bus.signal_power), m_sig);
            chk("error_power",  longint'(bus.error_power),  m_errp);
            chk("peak_error",   longint'(bus.peak_error),   m_peak);
        end
    end

    // Result capture for literal checks.
    int     rv_cnt = 0;
    longint rv_time, rv_sig, rv_err, rv_peak;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                rv_cnt++;
                rv_time = longint'($time);
                rv_sig  = longint'(bus.signal_power);
                rv_err  = longint'(bus.error_power);
                rv_peak = longint'(bus.peak_error);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic longint pref(input int t, input int k);
        case (t)
            1:       return 16384;
            2:       return (k % 2 == 0) ? 16384 : -16384;
            3:       return -131072;
            4:       return 8000;
            default: return 0;
        endcase
    endfunction

    function automatic longint perr(input int t, input int k);
        case (t)
            1:       return 1024;
            2:       return (k % 2 == 0) ? 1024 : -1024;
            3:       return -131072;
            4:       return (k == 4) ? 4000 : 0;
            default: return 0;
        endcase
    endfunction

    // Holds one symbol on the inputs until an enable edge has captured it.
    task automatic sym(input longint r, input longint e);
        int guard;
        bus.errorless_decision_variable = DW'(r);
        bus.error = DW'(e);
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!bus.clk_en && guard < 64);
        if (!bus.clk_en) chk("clk_en_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_window(input int t, input longint es, input longint ee,
                              input longint ep, input bit mid_start, input bit done_start);
        int     rv0;
        longint t0;
        rv0 = rv_cnt;
        sym(pref(t, -1), perr(t, -1));
        bus.start = 1'b1;
        t0 = longint'($time);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if ((mid_start && k == 5) || (done_start && k == 16)) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            sym(pref(t, k), perr(t, k));
        end
        @(negedge clk);
        chk($sformatf("w%0d_pulses", t),  longint'(rv_cnt - rv0), 1);
        chk($sformatf("w%0d_sig", t),     rv_sig, es);
        chk($sformatf("w%0d_err", t),     rv_err, ee);
        chk($sformatf("w%0d_peak", t),    rv_peak, ep);
        chk($sformatf("w%0d_latency", t), rv_time - t0, 2570);
        chk($sformatf("w%0d_busy", t),    longint'(bus.busy), 0);
    endtask

    initial begin
        int rv0;
        bus.start = 1'b0;
        bus.errorless_decision_variable = '0;
        bus.error = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_rv",   longint'(bus.result_valid), 0);
        chk("rst_sig",  longint'(bus.signal_power), 0);
        chk("rst_err",  longint'(bus.error_power), 0);
        chk("rst_peak", longint'(bus.peak_error), 0);
        reset = 1'b0;
        @(negedge clk);

        run_window(1, 268435456, 1048576, 1024, 1'b0, 1'b0);
        run_window(2, 268435456, 1048576, 1024, 1'b0, 1'b0);
        run_window(3, 64'd17179869184, 64'd17179869184, 131072, 1'b0, 1'b0);
        run_window(4, 64000000, 1000000, 4000, 1'b1, 1'b1);

        // Abort a window half way through with reset.
        rv0 = rv_cnt;
        sym(pref(3, -1), perr(3, -1));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) sym(pref(3, k), perr(3, k));
        chk("pre_abort_busy", longint'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", longint'(bus.busy), 0);
        chk("abort_rv",   longint'(bus.result_valid), 0);
        chk("abort_sig",  longint'(bus.signal_power), 0);
        chk("abort_err",  longint'(bus.error_power), 0);
        chk("abort_peak", longint'(bus.peak_error), 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_pulse", longint'(rv_cnt - rv0), 0);

        run_window(1, 268435456, 1048576, 1024, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
